// File: rtl/dram_read_responder.sv
// dram_read_responder: responder end of the DRAM read interface for the
// graph pipeline's property-fetch stages. Word read requests enter a small
// in-order queue. A three-state engine pops each one, waits LATENCY cycles,
// and returns one 64-bit word with a single-cycle complete pulse.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   req_valid/req_addr    read request (byte address, word = addr >> 3)
//   req_accept            queue not full; the request is taken on this edge
//   wr_en/wr_addr/wr_data backing-array write port, open every cycle
//   src_data              response word, held between responses
//   complete              one-cycle pulse marking src_data valid
//   resp_err              out-of-range flag, qualified by complete
//                         (present only with DRAM_RESP_BOUNDS_EN)
//
// Optional feature macro: DRAM_RESP_BOUNDS_EN. When it is defined, addresses
// past the array return zero data with resp_err set, and such writes are
// dropped. When it is undefined, every address wraps modulo DEPTH.
module dram_read_responder #(
  parameter int ADDR_W  = 32,
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 4,
  parameter int QDEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_accept,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [63:0]       wr_data,
  output logic [63:0]       src_data,
  output logic              complete
`ifdef DRAM_RESP_BOUNDS_EN
  ,
  output logic              resp_err
`endif
);

  localparam int              IDX_W    = $clog2(DEPTH);
  localparam int              QP_W     = $clog2(QDEPTH);
  localparam logic [7:0]      CNT_LOAD = 8'(LATENCY - 1);
  localparam logic [QP_W:0]   Q_FULL   = (QP_W + 1)'(QDEPTH);

  // Byte-address bits below the word offset and above the index are not
  // needed for indexing. This sink keeps them visibly consumed.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr, wr_addr};

  // --------------------------------------------------------------------
  // Backing word array (contents are never reset)
  // --------------------------------------------------------------------
  logic [63:0] mem [DEPTH];
  logic        wr_ok;

`ifdef DRAM_RESP_BOUNDS_EN
  // An address is out of range when any bit above the word index is set.
  function automatic logic is_oob(input logic [ADDR_W-1:0] a);
    return (a >> (3 + IDX_W)) != '0;
  endfunction

  assign wr_ok = wr_en && !is_oob(wr_addr);
`else
  assign wr_ok = wr_en;
`endif

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr[3 +: IDX_W]] <= wr_data;
    end
  end

  // --------------------------------------------------------------------
  // Request queue
  // --------------------------------------------------------------------
  logic [IDX_W-1:0] q_idx [QDEPTH];
  logic [QP_W-1:0]  q_wptr;
  logic [QP_W-1:0]  q_rptr;
  logic [QP_W:0]    q_cnt;
  logic             q_empty;
  logic             q_full;
  logic             push;
  logic             pop;

  assign q_full  = (q_cnt == Q_FULL);
  assign q_empty = (q_cnt == '0);
  // Accept is taken from the registered count only. A pop on the same edge
  // therefore never makes room for that edge's push.
  assign req_accept = !q_full;
  assign push       = req_valid && !q_full;

  always_ff @(posedge clk) begin
    if (push) begin
      q_idx[q_wptr] <= req_addr[3 +: IDX_W];
    end
  end

`ifdef DRAM_RESP_BOUNDS_EN
  logic q_oob [QDEPTH];

  always_ff @(posedge clk) begin
    if (push) begin
      q_oob[q_wptr] <= is_oob(req_addr);
    end
  end
`endif

  // QDEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_wptr <= '0;
      q_rptr <= '0;
      q_cnt  <= '0;
    end else begin
      if (push) begin
        q_wptr <= q_wptr + 1'b1;
      end
      if (pop) begin
        q_rptr <= q_rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   q_cnt <= q_cnt + 1'b1;
        2'b01:   q_cnt <= q_cnt - 1'b1;
        default: q_cnt <= q_cnt;
      endcase
    end
  end

  // --------------------------------------------------------------------
  // Engine FSM
  // --------------------------------------------------------------------
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       cnt;
  logic [IDX_W-1:0] lat_idx;
  logic             load;   // pop the head and start a new access
  logic             fetch;  // final WAIT cycle: sample the array

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (!q_empty) state_nxt = ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nxt = ST_RESP;
      ST_RESP: state_nxt = q_empty ? ST_IDLE : ST_WAIT;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output logic. RESP reloads directly into WAIT, so back-to-back
  // responses are LATENCY+1 cycles apart and complete never lasts two cycles.
  always_comb begin
    complete = 1'b0;
    load     = 1'b0;
    fetch    = 1'b0;
    case (state)
      ST_IDLE: load = !q_empty;
      ST_WAIT: fetch = (cnt == '0);
      ST_RESP: begin
        complete = 1'b1;
        load     = !q_empty;
      end
      default: ;
    endcase
  end

  assign pop = load;

  // --------------------------------------------------------------------
  // Access datapath
  // --------------------------------------------------------------------
`ifdef DRAM_RESP_BOUNDS_EN
  logic lat_oob;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      lat_idx  <= '0;
      src_data <= '0;
`ifdef DRAM_RESP_BOUNDS_EN
      lat_oob  <= 1'b0;
      resp_err <= 1'b0;
`endif
    end else begin
      if (load) begin
        cnt     <= CNT_LOAD;
        lat_idx <= q_idx[q_rptr];
`ifdef DRAM_RESP_BOUNDS_EN
        lat_oob <= q_oob[q_rptr];
`endif
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      // The array write on this edge is non-blocking, so a same-index write
      // leaves the response with the pre-write word.
      if (fetch) begin
`ifdef DRAM_RESP_BOUNDS_EN
        src_data <= lat_oob ? 64'd0 : mem[lat_idx];
        resp_err <= lat_oob;
`else
        src_data <= mem[lat_idx];
`endif
      end
    end
  end

endmodule
